// File: rtl/register_file.sv
// 32 x DATA_W register file: two combinational read ports, one synchronous write port, x0 hard-wired to zero.
// Define REGFILE_WRITE_BYPASS_EN to forward WD3 to a read port addressing the register being written.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [NREG];
    logic [NREG-1:0]   wr_en;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    // One-hot write decode; entry 0 never enables, so x0 keeps its reset value.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_dec
            if (gi == 0) begin : g_x0
                assign wr_en[gi] = 1'b0;
            end else begin : g_xn
                assign wr_en[gi] = WE3 && (A3 == ADDR_W'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= WD3;
                end
            end
        end
    end

    // Address 0 is masked explicitly so x0 reads zero even before the first reset.
    always_comb begin
        rd1_next = '0;
        rd2_next = '0;
        if (!rst) begin
            if (A1 != '0) rd1_next = regs_reg[A1];
            if (A2 != '0) rd2_next = regs_reg[A2];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (WE3 && (A3 != '0) && (A1 == A3)) rd1_next = WD3;
            if (WE3 && (A3 != '0) && (A2 == A3)) rd2_next = WD3;
`else
`endif
        end
    end

    assign RD1 = rd1_next;
    assign RD2 = rd2_next;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic against an array model.
module tb_register_file;
    logic        clk;
    logic        rst;
    logic        WE3;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2;

    int vectors;
    int miscompares;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0] model [32];

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .WE3(WE3),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value for the current inputs, from the behavioural rules.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'h0;
        if (BYPASS && WE3 && A3 != 5'd0 && A3 == a) return WD3;
        return model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one rising edge, update the model from the values sampled there, return at the falling edge.
    task automatic edge_cycle();
        @(posedge clk);
        if (!rst && WE3 && A3 != 5'd0) model[A3] = WD3;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 A1 = 5'd5; A2 = 5'd31;
        #1;
        model_clear();
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL reset_rd1: got %h want %h", RD1, 32'h0); end
        vectors++;
        if (RD2 !== 32'h0) begin miscompares++; $display("FAIL reset_rd2: got %h want %h", RD2, 32'h0); end
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL reset_write_ignored: got %h want %h", RD1, 32'h0); end
        @(negedge clk);
        rst = 1'b0; WE3 = 1'b0;
        #1;
        e = exp_rd(A1);
        vectors++;
        if (RD1 !== e) begin miscompares++; $display("FAIL reset_after_release: got %h want %h", RD1, e); end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'hDEADBEEF;
        edge_cycle();
        WE3 = 1'b0; A1 = 5'd7; A2 = 5'd8;
        #1;
        vectors++;
        if (RD1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_read_rd1: got %h want %h", RD1, 32'hDEADBEEF); end
        vectors++;
        if (RD2 !== 32'h0) begin miscompares++; $display("FAIL write_read_rd2: got %h want %h", RD2, 32'h0); end
        A2 = 5'd7;
        #1;
        vectors++;
        if (RD2 !== RD1 || RD2 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL same_addr_both_ports: got %h/%h want %h", RD1, RD2, 32'hDEADBEEF); end
        $display("test_write_read done");
    endtask

    task automatic test_x0();
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL x0_no_forward: got %h want %h", RD1, 32'h0); end
        edge_cycle();
        WE3 = 1'b0;
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL x0_write_discard: got %h want %h", RD1, 32'h0); end
        $display("test_x0 done");
    endtask

    task automatic test_write_disable();
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h0BADC0DE;
        edge_cycle();
        WE3 = 1'b0; A3 = 5'd3; WD3 = 32'h12345678; A1 = 5'd3;
        edge_cycle();
        #1;
        vectors++;
        if (RD1 !== 32'h0BADC0DE) begin miscompares++; $display("FAIL write_disable: got %h want %h", RD1, 32'h0BADC0DE); end
        $display("test_write_disable done");
    endtask

    task automatic test_same_cycle();
        logic [31:0] e;
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h11112222;
        edge_cycle();
        A1 = 5'd9; A2 = 5'd10; A3 = 5'd9; WD3 = 32'hA5A5A5A5; WE3 = 1'b1;
        #1;
        e = BYPASS ? 32'hA5A5A5A5 : 32'h11112222;
        vectors++;
        if (RD1 !== e) begin miscompares++; $display("FAIL same_cycle_before_edge: got %h want %h", RD1, e); end
        edge_cycle();
        WE3 = 1'b0;
        #1;
        vectors++;
        if (RD1 !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL same_cycle_after_edge: got %h want %h", RD1, 32'hA5A5A5A5); end
        $display("test_same_cycle done");
    endtask

    task automatic test_reset_during_write();
        WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h77777777;
        edge_cycle();
        WD3 = 32'h1; A1 = 5'd4; A2 = 5'd7;
        @(posedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL reset_during_write: got %h want %h", RD1, 32'h0); end
        @(negedge clk);
        rst = 1'b0; WE3 = 1'b0;
        #1;
        vectors++;
        if (RD1 !== 32'h0) begin miscompares++; $display("FAIL reg4_after_reset: got %h want %h", RD1, 32'h0); end
        vectors++;
        if (RD2 !== 32'h0) begin miscompares++; $display("FAIL reg7_after_reset: got %h want %h", RD2, 32'h0); end
        WE3 = 1'b1; A3 = 5'd4; WD3 = 32'h5A5A0001;
        edge_cycle();
        WE3 = 1'b0;
        #1;
        vectors++;
        if (RD1 !== 32'h5A5A0001) begin miscompares++; $display("FAIL first_write_after_reset: got %h want %h", RD1, 32'h5A5A0001); end
        $display("test_reset_during_write done");
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 120; n++) begin
            WE3 = 1'($urandom_range(0, 3) != 0);
            A3  = 5'($urandom_range(0, 31));
            WD3 = $urandom;
            A1  = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
            A2  = ($urandom_range(0, 4) == 0) ? A1 : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(A1);
            e2 = exp_rd(A2);
            $display("txn %0d we=%0b a3=%0d wd=%h a1=%0d rd1=%h a2=%0d rd2=%h", n, WE3, A3, WD3, A1, RD1, A2, RD2);
            vectors++;
            if (RD1 !== e1) begin miscompares++; $display("FAIL rand_rd1 txn %0d: got %h want %h", n, RD1, e1); end
            vectors++;
            if (RD2 !== e2) begin miscompares++; $display("FAIL rand_rd2 txn %0d: got %h want %h", n, RD2, e2); end
            edge_cycle();
        end
        // Sweep every register against the model to catch writes that leaked elsewhere.
        WE3 = 1'b0;
        for (int a = 0; a < 32; a++) begin
            A1 = 5'(a); A2 = 5'(31 - a);
            #1;
            e1 = exp_rd(A1);
            e2 = exp_rd(A2);
            vectors++;
            if (RD1 !== e1 || RD2 !== e2) begin miscompares++; $display("FAIL sweep addr %0d: got %h/%h want %h/%h", a, RD1, RD2, e1, e2); end
        end
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
        vectors = 0; miscompares = 0;
        model_clear();
        test_reset();
        test_write_read();
        test_x0();
        test_write_disable();
        test_same_cycle();
        test_reset_during_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
